// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: keystream-stage FSM states, plaintext character bounds
// and the plaintext validity test used to reject candidate keys.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_INC_I   = 4'd2,
    ST_WAIT1   = 4'd3,
    ST_RD_SI   = 4'd4,
    ST_SET_SJ  = 4'd5,
    ST_WAIT2   = 4'd6,
    ST_RD_SJ   = 4'd7,
    ST_WR_SI   = 4'd8,
    ST_WR_SJ   = 4'd9,
    ST_SET_F   = 4'd10,
    ST_WAIT3   = 4'd11,
    ST_RD_F    = 4'd12,
    ST_WR_DEC  = 4'd13,
    ST_CHECK_K = 4'd14,
    ST_DONE    = 4'd15
  } decrypt_state_t;

  localparam logic [7:0] CHAR_LO         = 8'h61;
  localparam logic [7:0] CHAR_HI         = 8'h7A;
  localparam logic [7:0] CHAR_SPACE      = 8'h20;
  localparam int         DEFAULT_MSG_LEN = 32;

  // Lowercase letters and space are the only bytes a correct key can produce.
  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SPACE);
  endfunction

  // Message index width; a one-byte message still needs a one-bit address.
  function automatic int msg_addr_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/decrypt_message_if.sv
// Control handshake plus the S, encrypted-ROM and decrypted-RAM buses of the
// RC4 keystream/decrypt stage. The slave side is the decryptor itself.
interface decrypt_message_if
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = DEFAULT_MSG_LEN
) ();

  localparam int AW = msg_addr_width(MSG_LEN);

  logic          start;
  logic          finish;
  logic          bad_key;
  logic [7:0]    s_address;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] enc_address;
  logic [7:0]    enc_q;
  logic [AW-1:0] dec_address;
  logic [7:0]    dec_data;
  logic          dec_wren;

  modport master (
    output start, s_q, enc_q,
    input  finish, bad_key, s_address, s_data, s_wren,
           enc_address, dec_address, dec_data, dec_wren
  );

  modport slave (
    input  start, s_q, enc_q,
    output finish, bad_key, s_address, s_data, s_wren,
           enc_address, dec_address, dec_data, dec_wren
  );

endinterface

// File: rtl/decrypt_message.sv
// RC4 pseudo-random generation stage: walks S with the i/j swap, XORs each
// keystream byte with the encrypted ROM and writes plaintext to the output RAM.
module decrypt_message
  import rc4_pkg::*;
#(
  parameter int MSG_LEN      = DEFAULT_MSG_LEN,
  parameter bit ABORT_ON_BAD = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  decrypt_message_if.slave        bus
);

  localparam int            AW     = msg_addr_width(MSG_LEN);
  localparam logic [AW-1:0] K_ONE  = AW'(1);
  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  decrypt_state_t state_r;
  logic [7:0]     i_r;
  logic [7:0]     j_r;
  logic [7:0]     si_r;
  logic [7:0]     sj_r;
  logic [7:0]     f_r;
  logic [7:0]     e_r;
  logic [AW-1:0]  k_r;

  logic           finish_r;
  logic           bad_key_r;
  logic [7:0]     s_address_r;
  logic [7:0]     s_data_r;
  logic           s_wren_r;
  logic [AW-1:0]  enc_address_r;
  logic [AW-1:0]  dec_address_r;
  logic [7:0]     dec_data_r;
  logic           dec_wren_r;

  assign bus.finish      = finish_r;
  assign bus.bad_key     = bad_key_r;
  assign bus.s_address   = s_address_r;
  assign bus.s_data      = s_data_r;
  assign bus.s_wren      = s_wren_r;
  assign bus.enc_address = enc_address_r;
  assign bus.dec_address = dec_address_r;
  assign bus.dec_data    = dec_data_r;
  assign bus.dec_wren    = dec_wren_r;

  // FSM and datapath: each state loads the registered outputs seen in the next
  // state, so strobes are high for exactly the WR_SI, WR_SJ, WR_DEC and DONE cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      i_r           <= 8'd0;
      j_r           <= 8'd0;
      si_r          <= 8'd0;
      sj_r          <= 8'd0;
      f_r           <= 8'd0;
      e_r           <= 8'd0;
      k_r           <= '0;
      finish_r      <= 1'b0;
      bad_key_r     <= 1'b0;
      s_address_r   <= 8'd0;
      s_data_r      <= 8'd0;
      s_wren_r      <= 1'b0;
      enc_address_r <= '0;
      dec_address_r <= '0;
      dec_data_r    <= 8'd0;
      dec_wren_r    <= 1'b0;
    end else begin
      s_wren_r   <= 1'b0;
      dec_wren_r <= 1'b0;
      finish_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_INIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INIT: begin
          i_r       <= 8'd0;
          j_r       <= 8'd0;
          k_r       <= '0;
          bad_key_r <= 1'b0;
          state_r   <= ST_INC_I;
        end
        ST_INC_I: begin
          i_r         <= i_r + 8'd1;
          s_address_r <= i_r + 8'd1;
          state_r     <= ST_WAIT1;
        end
        ST_WAIT1: state_r <= ST_RD_SI;
        ST_RD_SI: begin
          si_r    <= bus.s_q;
          j_r     <= j_r + bus.s_q;
          state_r <= ST_SET_SJ;
        end
        ST_SET_SJ: begin
          s_address_r <= j_r;
          state_r     <= ST_WAIT2;
        end
        ST_WAIT2: state_r <= ST_RD_SJ;
        // Captured S[j] goes straight onto the write bus for the S[i] half of the swap.
        ST_RD_SJ: begin
          sj_r        <= bus.s_q;
          s_address_r <= i_r;
          s_data_r    <= bus.s_q;
          s_wren_r    <= 1'b1;
          state_r     <= ST_WR_SI;
        end
        ST_WR_SI: begin
          s_address_r <= j_r;
          s_data_r    <= si_r;
          s_wren_r    <= 1'b1;
          state_r     <= ST_WR_SJ;
        end
        ST_WR_SJ: state_r <= ST_SET_F;
        ST_SET_F: begin
          s_address_r   <= si_r + sj_r;
          enc_address_r <= k_r;
          state_r       <= ST_WAIT3;
        end
        ST_WAIT3: state_r <= ST_RD_F;
        ST_RD_F: begin
          f_r           <= bus.s_q;
          e_r           <= bus.enc_q;
          dec_address_r <= k_r;
          dec_data_r    <= bus.s_q ^ bus.enc_q;
          dec_wren_r    <= 1'b1;
          state_r       <= ST_WR_DEC;
        end
        ST_WR_DEC: begin
          if (!is_valid_char(f_r ^ e_r)) begin
            bad_key_r <= 1'b1;
          end else begin
            bad_key_r <= bad_key_r;
          end
          state_r <= ST_CHECK_K;
        end
        ST_CHECK_K: begin
          if ((k_r == K_LAST) || (ABORT_ON_BAD && bad_key_r)) begin
            finish_r <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            k_r     <= k_r + K_ONE;
            state_r <= ST_INC_I;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_message.sv
// Directed bench for decrypt_message: instance A runs all bytes, instance B
// aborts on the first bad byte. Both use synchronous S/ROM/RAM models.
module tb_decrypt_message;
  import rc4_pkg::*;

  localparam int LEN = 32;
  localparam int AW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_a, start_b;
  logic load_a, load_b;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [7:0]    s_mem_a [256];
  logic [7:0]    enc_mem_a [LEN];
  logic [7:0]    dec_mem_a [LEN];
  logic [7:0]    s_addr_ra;
  logic [AW-1:0] enc_addr_ra;
  logic [7:0]    s_mem_b [256];
  logic [7:0]    enc_mem_b [LEN];
  logic [7:0]    dec_mem_b [LEN];
  logic [7:0]    s_addr_rb;
  logic [AW-1:0] enc_addr_rb;
  int            wr1_cnt_b;

  logic [7:0] ms [256];
  logic [7:0] ks [LEN];

  decrypt_message_if #(.MSG_LEN(LEN)) bus_a ();
  decrypt_message_if #(.MSG_LEN(LEN)) bus_b ();

  decrypt_message #(.MSG_LEN(LEN), .ABORT_ON_BAD(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
  decrypt_message #(.MSG_LEN(LEN), .ABORT_ON_BAD(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

  assign bus_a.start = start_a;
  assign bus_a.s_q   = s_mem_a[s_addr_ra];
  assign bus_a.enc_q = enc_mem_a[enc_addr_ra];
  assign bus_b.start = start_b;
  assign bus_b.s_q   = s_mem_b[s_addr_rb];
  assign bus_b.enc_q = enc_mem_b[enc_addr_rb];

  always @(posedge clk) begin
    if (load_a) begin
      for (int x = 0; x < 256; x++) s_mem_a[x] <= 8'(x);
      for (int x = 0; x < LEN; x++) dec_mem_a[x] <= 8'hFF;
    end else begin
      if (bus_a.s_wren) s_mem_a[bus_a.s_address] <= bus_a.s_data;
      if (bus_a.dec_wren) dec_mem_a[bus_a.dec_address] <= bus_a.dec_data;
    end
    s_addr_ra   <= bus_a.s_address;
    enc_addr_ra <= bus_a.enc_address;
  end

  always @(posedge clk) begin
    if (load_b) begin
      for (int x = 0; x < 256; x++) s_mem_b[x] <= 8'(x);
      for (int x = 0; x < LEN; x++) dec_mem_b[x] <= 8'hFF;
      wr1_cnt_b <= 0;
    end else begin
      if (bus_b.s_wren) s_mem_b[bus_b.s_address] <= bus_b.s_data;
      if (bus_b.dec_wren) dec_mem_b[bus_b.dec_address] <= bus_b.dec_data;
      if (bus_b.s_wren && bus_b.s_address == 8'd1) wr1_cnt_b <= wr1_cnt_b + 1;
    end
    s_addr_rb   <= bus_b.s_address;
    enc_addr_rb <= bus_b.enc_address;
  end

  // Reference RC4 PRGA starting from the identity permutation.
  task automatic model_prga(input int nbytes);
    logic [7:0] mi, mj, t, fi;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mi = 8'd0;
    mj = 8'd0;
    for (int n = 0; n < nbytes; n++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      fi = ms[mi] + ms[mj];
      ks[n] = ms[fi];
    end
  endtask

  task automatic load_mem_a();
    @(negedge clk); load_a = 1'b1;
    @(negedge clk); load_a = 1'b0;
  endtask

  task automatic load_mem_b();
    @(negedge clk); load_b = 1'b1;
    @(negedge clk); load_b = 1'b0;
  endtask

  // Raise start so the next rising edge (E0) samples it, then drop it.
  task automatic kick_a(input logic hold);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = hold;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dut_a.state_r !== ST_IDLE) begin
      n_fails++; $display("FAIL reset_state: got %0d expected %0d", dut_a.state_r, ST_IDLE);
    end
    n_checks++;
    if ({bus_a.finish, bus_a.bad_key, bus_a.s_wren, bus_a.dec_wren} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_flags: got %b expected 0000",
        {bus_a.finish, bus_a.bad_key, bus_a.s_wren, bus_a.dec_wren});
    end
    n_checks++;
    if ({bus_a.s_address, bus_a.s_data, bus_a.dec_data} !== 24'h0) begin
      n_fails++; $display("FAIL reset_buses: got %h expected 000000",
        {bus_a.s_address, bus_a.s_data, bus_a.dec_data});
    end
  endtask

  task automatic test_zero_rom();
    int cnt, fin;
    for (int x = 0; x < LEN; x++) enc_mem_a[x] = 8'h00;
    load_mem_a();
    kick_a(1'b0);
    cnt = 0; fin = 0;
    while (fin == 0 && cnt < 600) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 28) begin
        n_checks++;
        if (s_mem_a[2] !== 8'h03 || s_mem_a[3] !== 8'h02) begin
          n_fails++; $display("FAIL zero_swap: got s2=%h s3=%h expected s2=03 s3=02", s_mem_a[2], s_mem_a[3]);
        end
      end
      if (bus_a.finish === 1'b1) fin = cnt;
    end
    n_checks++;
    if (fin != 417) begin n_fails++; $display("FAIL zero_finish_time: got %0d expected 417", fin); end
    n_checks++;
    if (bus_a.bad_key !== 1'b1) begin n_fails++; $display("FAIL zero_bad_key: got %b expected 1", bus_a.bad_key); end
    n_checks++;
    if (dec_mem_a[0] !== 8'h02 || dec_mem_a[1] !== 8'h05) begin
      n_fails++; $display("FAIL zero_dec: got %h %h expected 02 05", dec_mem_a[0], dec_mem_a[1]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_a.finish !== 1'b0) begin n_fails++; $display("FAIL finish_pulse: got %b expected 0", bus_a.finish); end
  endtask

  task automatic test_plaintext();
    int cnt, fin, bad_dec, bad_s;
    model_prga(LEN);
    for (int x = 0; x < LEN; x++) enc_mem_a[x] = ks[x] ^ (8'h61 + 8'(x % 26));
    load_mem_a();
    kick_a(1'b0);
    cnt = 0; fin = 0;
    while (fin == 0 && cnt < 600) begin
      @(posedge clk); #1; cnt++;
      if (bus_a.finish === 1'b1) fin = cnt;
    end
    n_checks++;
    if (fin != 417) begin n_fails++; $display("FAIL pt_finish_time: got %0d expected 417", fin); end
    n_checks++;
    if (bus_a.bad_key !== 1'b0) begin n_fails++; $display("FAIL pt_bad_key: got %b expected 0", bus_a.bad_key); end
    bad_dec = 0;
    for (int x = 0; x < LEN; x++) if (dec_mem_a[x] !== (8'h61 + 8'(x % 26))) bad_dec++;
    n_checks++;
    if (bad_dec != 0) begin
      n_fails++; $display("FAIL pt_dec: got %0d wrong bytes (dec0=%h) expected 0", bad_dec, dec_mem_a[0]);
    end
    bad_s = 0;
    for (int x = 0; x < 256; x++) if (s_mem_a[x] !== ms[x]) bad_s++;
    n_checks++;
    if (bad_s != 0) begin n_fails++; $display("FAIL pt_final_s: got %0d wrong entries expected 0", bad_s); end
  endtask

  task automatic test_abort();
    int cnt, fin;
    for (int x = 0; x < LEN; x++) enc_mem_b[x] = 8'h00;
    load_mem_b();
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    cnt = 0; fin = 0;
    while (fin == 0 && cnt < 600) begin
      @(posedge clk); #1; cnt++;
      if (bus_b.finish === 1'b1) fin = cnt;
    end
    n_checks++;
    if (fin != 14) begin n_fails++; $display("FAIL abort_finish_time: got %0d expected 14", fin); end
    n_checks++;
    if (bus_b.bad_key !== 1'b1) begin n_fails++; $display("FAIL abort_bad_key: got %b expected 1", bus_b.bad_key); end
    n_checks++;
    if (dec_mem_b[0] !== 8'h02 || dec_mem_b[1] !== 8'hFF) begin
      n_fails++; $display("FAIL abort_dec: got %h %h expected 02 ff", dec_mem_b[0], dec_mem_b[1]);
    end
    n_checks++;
    if (s_mem_b[1] !== 8'h01 || wr1_cnt_b != 2) begin
      n_fails++; $display("FAIL i_eq_j: got s1=%h writes=%0d expected s1=01 writes=2", s_mem_b[1], wr1_cnt_b);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt, fin;
    for (int x = 0; x < LEN; x++) enc_mem_a[x] = 8'h00;
    load_mem_a();
    kick_a(1'b0);
    repeat (99) @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.s_wren !== 1'b1) begin n_fails++; $display("FAIL pre_reset_wren: got %b expected 1", bus_a.s_wren); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.s_wren, bus_a.dec_wren, bus_a.finish, bus_a.bad_key} !== 4'b0000 ||
        {bus_a.s_address, bus_a.s_data} !== 16'h0 || dut_a.state_r !== ST_IDLE) begin
      n_fails++; $display("FAIL mid_reset: got wren=%b addr=%h state=%0d expected 0 00 0",
        bus_a.s_wren, bus_a.s_address, dut_a.state_r);
    end
    @(negedge clk); reset_n = 1'b1;
    load_mem_a();
    kick_a(1'b0);
    cnt = 0; fin = 0;
    while (fin == 0 && cnt < 600) begin
      @(posedge clk); #1; cnt++;
      if (bus_a.finish === 1'b1) fin = cnt;
    end
    n_checks++;
    if (fin != 417 || dec_mem_a[0] !== 8'h02 || dec_mem_a[1] !== 8'h05) begin
      n_fails++; $display("FAIL rerun_after_reset: got t=%0d dec=%h %h expected t=417 dec=02 05",
        fin, dec_mem_a[0], dec_mem_a[1]);
    end
  endtask

  task automatic test_start_ignored();
    int cnt, fin;
    for (int x = 0; x < LEN; x++) enc_mem_a[x] = 8'h00;
    load_mem_a();
    kick_a(1'b0);
    cnt = 0; fin = 0;
    while (fin == 0 && cnt < 600) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 50) start_a = 1'b1;
      if (cnt == 51) start_a = 1'b0;
      if (bus_a.finish === 1'b1) fin = cnt;
    end
    n_checks++;
    if (fin != 417 || dec_mem_a[1] !== 8'h05) begin
      n_fails++; $display("FAIL start_ignored: got t=%0d dec1=%h expected t=417 dec1=05", fin, dec_mem_a[1]);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, fin1, fin2;
    for (int x = 0; x < LEN; x++) enc_mem_a[x] = 8'h00;
    load_mem_a();
    kick_a(1'b1);
    cnt = 0; fin1 = 0; fin2 = 0;
    while (fin2 == 0 && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 421) begin
        n_checks++;
        if (bus_a.bad_key !== 1'b0) begin n_fails++; $display("FAIL b2b_bad_key_clear: got %b expected 0", bus_a.bad_key); end
      end
      if (bus_a.finish === 1'b1) begin
        if (fin1 == 0) begin
          fin1 = cnt;
          n_checks++;
          if (bus_a.bad_key !== 1'b1) begin n_fails++; $display("FAIL b2b_bad_key_first: got %b expected 1", bus_a.bad_key); end
        end else begin
          fin2 = cnt;
          start_a = 1'b0;
        end
      end
    end
    start_a = 1'b0;
    n_checks++;
    if (fin1 != 417 || fin2 != 836) begin
      n_fails++; $display("FAIL b2b_timing: got %0d %0d expected 417 836", fin1, fin2);
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_rom();
    test_plaintext();
    test_abort();
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decrypt_message.md
# decrypt_message

Keystream generator and message decryptor: the RC4 pseudo-random generation stage. Once the S memory has been key-scheduled and shuffled, this block walks S with the standard i/j swap, reads the keystream byte, XORs it with the encrypted-message ROM, and writes plaintext to the decrypted-message RAM. It raises `bad_key` when a plaintext byte is not lowercase ASCII or space, which lets the key-search controller reject the candidate key.

## Interface
- `MSG_LEN`, 32: message length in bytes, 1..256.
- `ABORT_ON_BAD`, 1: 1 means stop at the first invalid plaintext byte; 0 means always process all bytes.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level; sampled only in IDLE.
- `finish` output 1: one-cycle pulse in DONE.
- `bad_key` output 1: sticky invalid-plaintext flag, valid while `finish` is high.
- `s_address` output 8: S memory address.
- `s_data` output 8: S write data.
- `s_wren` output 1: S write enable.
- `s_q` input 8: S read data.
- `enc_address` output $clog2(MSG_LEN): encrypted ROM address.
- `enc_q` input 8: encrypted ROM read data.
- `dec_address` output $clog2(MSG_LEN): decrypted RAM address.
- `dec_data` output 8: decrypted RAM write data.
- `dec_wren` output 1: decrypted RAM write enable.

## Operation
- Memories are synchronous: the address is registered by the memory, so data is valid two states after the FSM registers the address. Each read uses an address state, a WAIT state, then a capture state.
- All outputs are registered. Reset clears every output and internal register to 0 and puts the FSM in IDLE.
- Registers:
  - `i`, `j`, `si`, `sj`, `f`, `e`: 8 bits each; all additions wrap mod 256.
  - `k`: message index, $clog2(MSG_LEN) bits.
- States and transitions:
  - IDLE: if `start`, go to INIT.
  - INIT: i=j=k=0; `bad_key`=0.
  - INC_I: i←i+1; `s_address`←i+1.
  - WAIT1.
  - RD_SI: `si`←`s_q`; j←j+`s_q`.
  - SET_SJ: `s_address`←j.
  - WAIT2.
  - RD_SJ: `sj`←`s_q`.
  - WR_SI: `s_address`=i, `s_data`=`sj`, `s_wren`=1.
  - WR_SJ: `s_address`=j, `s_data`=`si`, `s_wren`=1.
  - SET_F: `s_address`←`si`+`sj`; `enc_address`←k.
  - WAIT3.
  - RD_F: `f`←`s_q`; `e`←`enc_q`.
  - WR_DEC: `dec_address`=k, `dec_data`=`f`^`e`, `dec_wren`=1. If that byte is not in 0x61..0x7A and not 0x20, `bad_key`←1.
  - CHECK_K:
    - If k==MSG_LEN-1, or (`ABORT_ON_BAD` and `bad_key`), go to DONE.
    - Otherwise k←k+1 and go to INC_I.
  - DONE: `finish`=1; go to IDLE.
- Write enables are high only in WR_SI, WR_SJ and WR_DEC, for exactly one cycle each.
- If i==j, both swap writes go to the same address; the final value is `si`, which equals `sj`.
- `start` is ignored outside IDLE. If `start` is still high when the FSM returns to IDLE, a new run begins on the next edge. S is not restored between runs.
- Reset mid-run aborts immediately: write enables drop asynchronously, and memory contents are left as they were.

## Timing
- Each byte takes 13 cycles (INC_I through CHECK_K).
- With the start-sampling edge as E0, DONE is entered at edge E0+1+13·n, where n is the number of bytes processed. For MSG_LEN=32 that is E0+417.
- `finish` is high for exactly one cycle. `bad_key` holds its value until the next INIT or reset.
- No pipelining: the block has one outstanding memory access at a time.

## Structure
- Shared package `rc4_pkg`:
  - State enum `decrypt_state_t`.
  - Constants `CHAR_LO`=8'h61, `CHAR_HI`=8'h7A, `CHAR_SPACE`=8'h20, `DEFAULT_MSG_LEN`=32.
  - Function `is_valid_char`.
- No sub-module: a single FSM with its datapath is natural. The memories are instantiated by the parent.

## Test plan
- Identity S (s[x]=x), encrypted ROM all 0x00, `ABORT_ON_BAD`=0:
  - dec[0]=0x02 and dec[1]=0x05.
  - After byte 1, s[2]=0x03 and s[3]=0x02.
  - `bad_key`=1; `finish` at E0+417.
- Identity S, ROM = model keystream XOR "abcd…" (enc[0]=0x63, enc[1]=0x67, …):
  - All 32 plaintext bytes match.
  - `bad_key`=0.
  - Final S matches the C model.
- `ABORT_ON_BAD`=1, identity S, ROM all 0x00:
  - Only dec[0]=0x02 is written.
  - `finish` at E0+14; `bad_key`=1.
- `reset_n` low at cycle 100 of a run:
  - All outputs are 0 within the same cycle and the FSM is in IDLE.
  - A subsequent `start` runs from i=j=k=0.
- Pulse `start` mid-run: ignored. Hold `start` high across DONE: back-to-back runs, the second restarting one cycle after IDLE is re-entered, with `bad_key` cleared in INIT.
- Identity S with i==j on the first byte (i=j=1): s[1] remains 0x01, and two writes occur to address 1.
